pcie_completion_timeout_tracker: RTL and testbench

//  Per-tag completion timeout tracker for PCIe non-posted requests. On each request it

---
 rtl/pcie_completion_timeout_tracker.sv | 99 +++++++++
 tb/tb_pcie_completion_timeout_tracker.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pcie_completion_timeout_tracker.sv
// pcie_completion_timeout_tracker: per-tag completion timers with a valid/ready timeout report.
// Defining CPL_TIMEOUT_DISABLE_EN adds timeout_disable, which freezes all pending timers.
module pcie_completion_timeout_tracker #(
  parameter int NUM_TAGS = 8,
  parameter int TAG_W    = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CPL_TIMEOUT_DISABLE_EN
  input  logic             timeout_disable,
`endif
  input  logic [CNT_W-1:0] timeout_value,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  input  logic             cpl_valid,
  input  logic [TAG_W-1:0] cpl_tag,
  input  logic             cpl_last,
  output logic             timeout_valid,
  output logic [TAG_W-1:0] timeout_tag,
  input  logic             timeout_ready,
  output logic             spurious_cpl,
  output logic [TAG_W:0]   outstanding_cnt
);
  typedef enum logic [1:0] {IDLE, PENDING, EXPIRED} state_t;
  state_t           r_st  [NUM_TAGS];
  state_t           w_st  [NUM_TAGS];
  logic [CNT_W-1:0] r_cnt [NUM_TAGS];
  logic [CNT_W-1:0] w_cnt [NUM_TAGS];
  logic             r_tv, r_spur, w_tv, w_hs, w_dis;
  logic [TAG_W-1:0] r_tt, w_tt;
  logic [TAG_W:0]   r_oc, w_oc;
  logic [CNT_W-1:0] w_load;
`ifdef CPL_TIMEOUT_DISABLE_EN
  assign w_dis = timeout_disable;
`else
  assign w_dis = 1'b0;
`endif
  assign w_load          = timeout_value == '0 ? CNT_W'(1) : timeout_value;
  assign w_hs            = r_tv & timeout_ready;
  assign req_ready       = r_st[req_tag] == IDLE;
  assign timeout_valid   = r_tv;
  assign timeout_tag     = r_tt;
  assign spurious_cpl    = r_spur;
  assign outstanding_cnt = r_oc;
  always_comb begin
    w_st = r_st;
    w_cnt = r_cnt;
    w_tv = r_tv;
    w_tt = r_tt;
    w_oc = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (r_st[i] == PENDING) begin
        if (cpl_valid && cpl_last && cpl_tag == TAG_W'(i)) w_st[i] = IDLE;
        else if (!w_dis && r_cnt[i] <= CNT_W'(1)) begin
          w_st[i] = EXPIRED;
          w_cnt[i] = '0;
        end else if (!w_dis) w_cnt[i] = r_cnt[i] - CNT_W'(1);
      end
      if (r_st[i] == EXPIRED && w_hs && r_tt == TAG_W'(i)) w_st[i] = IDLE;
      if (r_st[i] == IDLE && req_valid && req_tag == TAG_W'(i)) begin
        w_st[i] = PENDING;
        w_cnt[i] = w_load;
      end
      w_oc = w_oc + (TAG_W+1)'(w_st[i] != IDLE);
    end
    // a presented report is held until accepted; only then is the lowest expired tag picked
    if (!r_tv || w_hs) begin
      w_tv = 1'b0;
      for (int i = NUM_TAGS-1; i >= 0; i--)
        if (w_st[i] == EXPIRED) begin
          w_tv = 1'b1;
          w_tt = TAG_W'(i);
        end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_st[i] <= IDLE;
        r_cnt[i] <= '0;
      end
      r_tv <= 1'b0;
      r_tt <= '0;
      r_spur <= 1'b0;
      r_oc <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_st[i] <= w_st[i];
        r_cnt[i] <= w_cnt[i];
      end
      r_tv <= w_tv;
      r_tt <= w_tt;
      r_spur <= cpl_valid && r_st[cpl_tag] != PENDING;
      r_oc <= w_oc;
    end
  end
endmodule

// File: tb/tb_pcie_completion_timeout_tracker.sv
// tb_pcie_completion_timeout_tracker: random and directed stimulus against a deadline-based reference model.
module tb_pcie_completion_timeout_tracker;
  localparam int N = 8, TW = 3, CW = 32;
  logic clk = 0, rst = 1;
  logic [CW-1:0] timeout_value = 0;
  logic req_valid = 0, cpl_valid = 0, cpl_last = 0, timeout_ready = 0, dis = 0;
  logic [TW-1:0] req_tag = 0, cpl_tag = 0;
  logic req_ready, timeout_valid, spurious_cpl;
  logic [TW-1:0] timeout_tag;
  logic [TW:0] outstanding_cnt;
  always #5 clk = ~clk;
  pcie_completion_timeout_tracker #(.NUM_TAGS(N), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef CPL_TIMEOUT_DISABLE_EN
    .timeout_disable(dis),
`endif
    .timeout_value(timeout_value), .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .timeout_valid(timeout_valid), .timeout_tag(timeout_tag), .timeout_ready(timeout_ready),
    .spurious_cpl(spurious_cpl), .outstanding_cnt(outstanding_cnt));
  int passed = 0, total = 0;
  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s actual=%0d expected=%0d t=%0t", n, a, e, $time);
  endtask
  // reference model: each pending tag holds an absolute expiry cycle
  int ms [N];
  longint dl [N];
  longint cyc = 0;
  bit mv = 0, msp = 0;
  int mt = 0, moc = 0;
  int q [$];
  always @(posedge clk) begin : model
    int os [N];
    bit acc;
    cyc++;
    if (rst) begin
      foreach (ms[i]) ms[i] = 0;
      mv = 0; mt = 0; msp = 0; moc = 0;
      q.delete();
    end else begin
      os = ms;
      acc = mv && timeout_ready;
      msp = cpl_valid && os[cpl_tag] != 1;
      for (int i = 0; i < N; i++) begin
        if (os[i] == 1) begin
          if (cpl_valid && cpl_last && int'(cpl_tag) == i) ms[i] = 0;
`ifdef CPL_TIMEOUT_DISABLE_EN
          else if (dis) dl[i]++;
`endif
          else if (cyc == dl[i]) ms[i] = 2;
        end
        if (os[i] == 2 && acc && mt == i) ms[i] = 0;
        if (os[i] == 0 && req_valid && int'(req_tag) == i) begin
          ms[i] = 1;
          dl[i] = cyc + (timeout_value == 0 ? 64'd1 : 64'(timeout_value));
        end
      end
      if (!(mv && !acc)) begin
        mv = 0;
        for (int i = N-1; i >= 0; i--) if (ms[i] == 2) begin mv = 1; mt = i; end
        if (mv) q.push_back(mt);
      end
      moc = 0;
      foreach (ms[i]) if (ms[i] != 0) moc++;
    end
  end
  bit lv = 0, lr = 0, lrst = 1;
  always @(negedge clk) begin
    #1;
    lv = timeout_valid; lr = timeout_ready; lrst = rst;
  end
  always @(posedge clk) begin : monitor
    int e;
    #1;
    chk("timeout_valid", timeout_valid, mv);
    if (mv) chk("timeout_tag", timeout_tag, mt);
    chk("spurious_cpl", spurious_cpl, msp);
    chk("outstanding_cnt", outstanding_cnt, moc);
    chk("req_ready", req_ready, ms[req_tag] == 0);
    if (!lrst && timeout_valid && !(lv && !lr)) begin
      if (q.size() == 0) chk("report_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("report_tag", timeout_tag, e);
      end
    end
  end
  task automatic drv(input bit rv, input int rt, input int v, input bit cv, input int ct,
                     input bit cl, input bit tr, input bit d);
    @(negedge clk);
    req_valid = rv; req_tag = TW'(rt); timeout_value = CW'(v);
    cpl_valid = cv; cpl_tag = TW'(ct); cpl_last = cl; timeout_ready = tr; dis = d;
  endtask
  task automatic idle(input int n, input bit tr);
    for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0, 0, tr, 0);
  endtask
  initial begin
    rst = 1; idle(3, 0);
    @(negedge clk) rst = 0;
    drv(1, 2, 16, 0, 0, 0, 0, 0); idle(20, 0); idle(3, 1);
    drv(1, 5, 16, 0, 0, 0, 0, 0); idle(9, 0); drv(0, 0, 0, 1, 5, 1, 0, 0); idle(3, 0);
    drv(1, 1, 8, 0, 0, 0, 0, 0); idle(7, 0); drv(0, 0, 0, 1, 1, 1, 0, 0); idle(3, 0);
    drv(1, 3, 10, 0, 0, 0, 0, 0); drv(1, 0, 9, 0, 0, 0, 0, 0); idle(14, 0);
    drv(0, 0, 0, 1, 6, 0, 0, 0); drv(0, 0, 0, 1, 3, 1, 0, 0); drv(1, 3, 5, 0, 0, 0, 0, 0);
    idle(2, 0); idle(4, 1);
    drv(1, 4, 0, 0, 0, 0, 0, 0); idle(3, 1);
`ifdef CPL_TIMEOUT_DISABLE_EN
    drv(1, 7, 10, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drv(0, 0, 0, 0, 0, 0, 0, 1);
    idle(14, 1);
`endif
    for (int i = 0; i < N; i++) drv(1, i, 1000, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1;
    idle(2, 0);
    @(negedge clk) rst = 0;
    idle(20, 1);
    for (int k = 0; k < 4000; k++) begin
      drv($urandom_range(0, 2) == 0, $urandom_range(0, N-1), $urandom_range(0, 30),
          $urandom_range(0, 3) == 0, $urandom_range(0, N-1), $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      rst = $urandom_range(0, 499) == 0;
    end
    @(negedge clk) rst = 0;
    idle(60, 1);
    chk("queue_drained", q.size(), 0);
    chk("final_outstanding", outstanding_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
